// File: rtl/riscv_pkg.sv
// Shared state encoding and opcode constants for the multicycle controller.
package riscv_pkg;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;

    typedef enum logic [3:0] {
        StFetch    = S_FETCH,
        StDecode   = S_DECODE,
        StMemAdr   = S_MEMADR,
        StMemRead  = S_MEMREAD,
        StMemWb    = S_MEMWB,
        StMemWrite = S_MEMWRITE,
        StExecR    = S_EXECR,
        StExecI    = S_EXECI,
        StAluWb    = S_ALUWB,
        StBeq      = S_BEQ,
        StJal      = S_JAL
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    // States that hold a memory request open until mem_ready.
    function automatic logic is_wait_state(state_t s);
        return (s == StFetch) || (s == StMemRead) || (s == StMemWrite);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory-wait counter; at_limit flags an all-ones count (2^TO_W-1 wait cycles).
module mc_wait_timer #(
    parameter int unsigned TO_W = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic inc,
    output logic at_limit
);

    logic [TO_W-1:0] count_q, count_d;

    assign at_limit = &count_q;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && !at_limit) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM with optional memory-wait timeout.
// Define MC_TIMEOUT_EN to build the timeout counter and mem_err reporting.
module multicycle_controller
    import riscv_pkg::*;
#(
    parameter int unsigned TO_W = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       pcwrite,
    output logic       adrsrc,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic [1:0] resultsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic       illegal_op,
    output logic       mem_err
);

    state_t state_q, state_d;
    logic   pcupdate, branch, timeout;

`ifdef MC_TIMEOUT_EN
    logic wait_st, at_limit, wt_clear, wt_inc;

    assign wait_st  = is_wait_state(state_q);
    assign timeout  = wait_st & at_limit & ~mem_ready;
    // Clearing on any state change doubles as "clear on entry" to the next wait state.
    assign wt_clear = (state_d != state_q) | timeout;
    assign wt_inc   = wait_st & ~mem_ready;

    mc_wait_timer #(
        .TO_W(TO_W)
    ) u_wait_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (wt_clear),
        .inc     (wt_inc),
        .at_limit(at_limit)
    );
`else
    logic unused_to_w;
    assign unused_to_w = ^TO_W;
    assign timeout     = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        adrsrc     = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        resultsrc  = 2'b00;
        alusrca    = 2'b00;
        alusrcb    = 2'b00;
        aluop      = 2'b00;
        illegal_op = 1'b0;
        pcupdate   = 1'b0;
        branch     = 1'b0;

        unique case (state_q)
            StFetch: begin
                mem_req   = 1'b1;
                resultsrc = 2'b10;
                alusrcb   = 2'b10;
                if (mem_ready) begin
                    irwrite  = 1'b1;
                    pcupdate = 1'b1;
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_d = StMemAdr;
                    OP_RTYPE:          state_d = StExecR;
                    OP_ITYPE:          state_d = StExecI;
                    OP_BEQ:            state_d = StBeq;
                    OP_JAL:            state_d = StJal;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = StFetch;
                    end
                endcase
            end
            StMemAdr: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                state_d = (op == OP_LOAD) ? StMemRead : StMemWrite;
            end
            StMemRead: begin
                mem_req = 1'b1;
                adrsrc  = 1'b1;
                if (mem_ready) begin
                    state_d = StMemWb;
                end else if (timeout) begin
                    state_d = StFetch;
                end
            end
            StMemWb: begin
                resultsrc = 2'b01;
                regwrite  = 1'b1;
                state_d   = StFetch;
            end
            StMemWrite: begin
                mem_req  = 1'b1;
                adrsrc   = 1'b1;
                memwrite = 1'b1;
                if (mem_ready || timeout) begin
                    state_d = StFetch;
                end
            end
            StExecR: begin
                alusrca = 2'b10;
                aluop   = 2'b10;
                state_d = StAluWb;
            end
            StExecI: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                aluop   = 2'b10;
                state_d = StAluWb;
            end
            StAluWb: begin
                regwrite = 1'b1;
                state_d  = StFetch;
            end
            StBeq: begin
                alusrca = 2'b10;
                aluop   = 2'b01;
                branch  = 1'b1;
                state_d = StFetch;
            end
            StJal: begin
                alusrca  = 2'b01;
                alusrcb  = 2'b10;
                pcupdate = 1'b1;
                state_d  = StAluWb;
            end
            default: state_d = StFetch;
        endcase

        mem_err = timeout;
        pcwrite = pcupdate | (branch & zero);

        // Reset must silence every strobe, including the FETCH mem_req.
        if (!reset_n) begin
            mem_req    = 1'b0;
            pcwrite    = 1'b0;
            adrsrc     = 1'b0;
            memwrite   = 1'b0;
            irwrite    = 1'b0;
            regwrite   = 1'b0;
            resultsrc  = 2'b00;
            alusrca    = 2'b00;
            alusrcb    = 2'b00;
            aluop      = 2'b00;
            illegal_op = 1'b0;
            mem_err    = 1'b0;
        end
    end

endmodule
